// File: rtl/wb_bank_arbiter.sv
// wb_bank_arbiter
//   Writeback arbiter between the two writeback ports of the issue/commit
//   pipeline and a 2-write, bank-interleaved (even/odd) register file. At most
//   one write is issued per bank per cycle. Writes that cannot issue wait in a
//   small in-order pending buffer, and upstream is backpressured through
//   wb_ready_o. The four read ports see the newest pending value.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   wb{0,1}_valid/addr/data  writeback requests (wb0 is older than wb1)
//   wb_ready_o               both writeback ports may present this cycle
//   wa/wd/we{0,1}_o          regfile write ports (port 0 even bank, port 1 odd)
//   ra{0..3}_i, rfd{0..3}_i  regfile read addresses and raw read data
//   rd{0..3}_o               read data with pending-buffer forwarding
//   pending_cnt_o            occupied buffer entries
//   idle_o                   buffer empty and no valid input
module wb_bank_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb0_valid_i,
  input  logic [4:0]                 wb0_addr_i,
  input  logic [WIDTH-1:0]           wb0_data_i,
  input  logic                       wb1_valid_i,
  input  logic [4:0]                 wb1_addr_i,
  input  logic [WIDTH-1:0]           wb1_data_i,
  output logic                       wb_ready_o,
  output logic [4:0]                 wa0_o,
  output logic [WIDTH-1:0]           wd0_o,
  output logic                       we0_o,
  output logic [4:0]                 wa1_o,
  output logic [WIDTH-1:0]           wd1_o,
  output logic                       we1_o,
  input  logic [4:0]                 ra0_i,
  input  logic [4:0]                 ra1_i,
  input  logic [4:0]                 ra2_i,
  input  logic [4:0]                 ra3_i,
  input  logic [WIDTH-1:0]           rfd0_i,
  input  logic [WIDTH-1:0]           rfd1_i,
  input  logic [WIDTH-1:0]           rfd2_i,
  input  logic [WIDTH-1:0]           rfd3_i,
  output logic [WIDTH-1:0]           rd0_o,
  output logic [WIDTH-1:0]           rd1_o,
  output logic [WIDTH-1:0]           rd2_o,
  output logic [WIDTH-1:0]           rd3_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt_o,
  output logic                       idle_o
);

  localparam int CW = $clog2(DEPTH + 1);
  // Candidate list: every buffer entry plus the two inputs.
  localparam int NC = DEPTH + 2;

  // Pending buffer as a shift FIFO: entry 0 is always the oldest.
  logic [DEPTH-1:0][4:0]       buf_addr_q, buf_addr_d;
  logic [DEPTH-1:0][WIDTH-1:0] buf_data_q, buf_data_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  logic                        ready_s;
  logic                        acc0_s, acc1_s;
  int                          pos0_s, pos1_s, cand_n_s;
  logic [NC-1:0][4:0]          buf_ext_addr_s, cand_addr_s;
  logic [NC-1:0][WIDTH-1:0]    buf_ext_data_s, cand_data_s;
  logic                        c0_iss_s, c1_iss_s;
  logic                        c0_even_s, c1_even_s;
  logic [3:0][4:0]             ra_s;
  logic [3:0][WIDTH-1:0]       rfd_s, rd_s;

  // Ready depends on registered occupancy only, so two accepts always fit.
  assign ready_s = !rst && (cnt_q <= CW'(DEPTH - 2));
  // Writes to r0 are accepted upstream but never enter the candidate list.
  assign acc0_s  = wb0_valid_i && ready_s && (wb0_addr_i != 5'd0);
  assign acc1_s  = wb1_valid_i && ready_s && (wb1_addr_i != 5'd0);

  // Slots where the accepted inputs land behind the buffered entries.
  always_comb begin
    pos0_s   = int'(cnt_q);
    pos1_s   = int'(cnt_q) + (acc0_s ? 1 : 0);
    cand_n_s = pos1_s + (acc1_s ? 1 : 0);
  end

  // Padding the buffer to NC entries keeps every constant index in range.
  assign buf_ext_addr_s = {{2{5'd0}}, buf_addr_q};
  assign buf_ext_data_s = {{2{{WIDTH{1'b0}}}}, buf_data_q};

  // Build the oldest-first candidate list: buffer entries, then wb0, then wb1.
  always_comb begin
    cand_addr_s = '0;
    cand_data_s = '0;
    for (int i = 0; i < NC; i++) begin
      if (i < pos0_s) begin
        cand_addr_s[i] = buf_ext_addr_s[i];
        cand_data_s[i] = buf_ext_data_s[i];
      end else if (acc0_s && (i == pos0_s)) begin
        cand_addr_s[i] = wb0_addr_i;
        cand_data_s[i] = wb0_data_i;
      end else if (acc1_s && (i == pos1_s)) begin
        cand_addr_s[i] = wb1_addr_i;
        cand_data_s[i] = wb1_data_i;
      end else begin
        cand_addr_s[i] = 5'd0;
        cand_data_s[i] = {WIDTH{1'b0}};
      end
    end
  end

  // In-order issue: C0 always goes, C1 only when it sits in the other bank.
  always_comb begin
    c0_iss_s  = (cand_n_s >= 1);
    c1_iss_s  = (cand_n_s >= 2) && (cand_addr_s[1][0] != cand_addr_s[0][0]);
    c0_even_s = c0_iss_s && !cand_addr_s[0][0];
    c1_even_s = c1_iss_s && !cand_addr_s[1][0];
  end

  // Port mapping by bank; enables are forced low while in reset.
  always_comb begin
    we0_o = !rst && (c0_even_s || c1_even_s);
    wa0_o = c0_even_s ? cand_addr_s[0] : cand_addr_s[1];
    wd0_o = c0_even_s ? cand_data_s[0] : cand_data_s[1];
    we1_o = !rst && ((c0_iss_s && !c0_even_s) || (c1_iss_s && !c1_even_s));
    wa1_o = (c0_iss_s && !c0_even_s) ? cand_addr_s[0] : cand_addr_s[1];
    wd1_o = (c0_iss_s && !c0_even_s) ? cand_data_s[0] : cand_data_s[1];
  end

  // Drop the issued head of the candidate list; the rest becomes the buffer.
  always_comb begin
    buf_addr_d = '0;
    buf_data_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (c1_iss_s) begin
        buf_addr_d[i] = cand_addr_s[i+2];
        buf_data_d[i] = cand_data_s[i+2];
      end else if (c0_iss_s) begin
        buf_addr_d[i] = cand_addr_s[i+1];
        buf_data_d[i] = cand_data_s[i+1];
      end else begin
        buf_addr_d[i] = cand_addr_s[i];
        buf_data_d[i] = cand_data_s[i];
      end
    end
    cnt_d = CW'(cand_n_s - (c0_iss_s ? 1 : 0) - (c1_iss_s ? 1 : 0));
  end

  // Pending buffer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_addr_q <= '0;
      buf_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ra_s  = {ra3_i, ra2_i, ra1_i, ra0_i};
  assign rfd_s = {rfd3_i, rfd2_i, rfd1_i, rfd0_i};

  // Forwarding: the youngest matching entry wins, so later hits override.
  // Entries issuing this cycle still forward since the regfile commits at the
  // next edge; current-cycle inputs are covered by the upstream bypass.
  always_comb begin
    rd_s = '0;
    for (int k = 0; k < 4; k++) begin
      rd_s[k] = rfd_s[k];
      for (int i = 0; i < DEPTH; i++) begin
        rd_s[k] = ((i < int'(cnt_q)) && (buf_addr_q[i] == ra_s[k])) ? buf_data_q[i] : rd_s[k];
      end
      rd_s[k] = (ra_s[k] == 5'd0) ? {WIDTH{1'b0}} : rd_s[k];
    end
  end

  assign rd0_o         = rd_s[0];
  assign rd1_o         = rd_s[1];
  assign rd2_o         = rd_s[2];
  assign rd3_o         = rd_s[3];
  assign wb_ready_o    = ready_s;
  assign pending_cnt_o = cnt_q;
  assign idle_o        = (cnt_q == '0) && !wb0_valid_i && !wb1_valid_i;

  wb_bank_arbiter_chk #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .wb0_valid(wb0_valid_i),
    .wb1_valid(wb1_valid_i),
    .wb_ready (ready_s),
    .we0      (we0_o),
    .wa0_bank (wa0_o[0]),
    .we1      (we1_o),
    .wa1_bank (wa1_o[0]),
    .cnt_d    (cnt_d)
  );

endmodule

// wb_bank_arbiter_chk
//   Protocol and structural invariants of wb_bank_arbiter.
// Ports
//   clk, rst            clock and reset of the arbiter
//   wb*_valid, wb_ready upstream handshake
//   we*/wa*_bank        issued write enables and their bank bits
//   cnt_d               next-cycle buffer occupancy
module wb_bank_arbiter_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          wb0_valid,
  input logic          wb1_valid,
  input logic          wb_ready,
  input logic          we0,
  input logic          wa0_bank,
  input logic          we1,
  input logic          wa1_bank,
  input logic [CW-1:0] cnt_d
);

  // Upstream must hold off while the arbiter is stalled.
  a_no_valid_when_stalled: assert property (@(posedge clk) disable iff (rst)
    !wb_ready |-> !(wb0_valid || wb1_valid))
    else $error("wb_bank_arbiter: valid asserted while wb_ready_o=0");

  // Each port only ever carries its own bank.
  a_port0_even: assert property (@(posedge clk) disable iff (rst) we0 |-> !wa0_bank)
    else $error("wb_bank_arbiter: odd address on port 0");
  a_port1_odd: assert property (@(posedge clk) disable iff (rst) we1 |-> wa1_bank)
    else $error("wb_bank_arbiter: even address on port 1");

  // No two writes into the same bank in one cycle.
  a_no_bank_conflict: assert property (@(posedge clk) disable iff (rst)
    !(we0 && we1 && (wa0_bank == wa1_bank)))
    else $error("wb_bank_arbiter: same-bank dual write");

  // Occupancy never exceeds DEPTH-1, so the buffer cannot overflow.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    cnt_d <= CW'(DEPTH - 1))
    else $error("wb_bank_arbiter: pending buffer overflow");

endmodule

// File: tb/tb_wb_bank_arbiter.sv
// Directed bench for wb_bank_arbiter with a per-bank write scoreboard and a
// behavioural register file feeding the raw read-data inputs.
module tb_wb_bank_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wb0_valid_i, wb1_valid_i;
  logic [4:0]       wb0_addr_i, wb1_addr_i;
  logic [WIDTH-1:0] wb0_data_i, wb1_data_i;
  logic             wb_ready_o;
  logic [4:0]       wa0_o, wa1_o;
  logic [WIDTH-1:0] wd0_o, wd1_o;
  logic             we0_o, we1_o;
  logic [4:0]       ra0_i, ra1_i, ra2_i, ra3_i;
  logic [WIDTH-1:0] rfd0_i, rfd1_i, rfd2_i, rfd3_i;
  logic [WIDTH-1:0] rd0_o, rd1_o, rd2_o, rd3_o;
  logic [CW-1:0]    pending_cnt_o;
  logic             idle_o;

  logic [WIDTH-1:0] mem [32];
  wr_t              exp_q0[$];
  wr_t              exp_q1[$];
  int               n_cmp = 0;
  int               n_err = 0;

  logic             pend_we0, pend_we1;
  logic [4:0]       pend_wa0, pend_wa1;
  logic [WIDTH-1:0] pend_wd0, pend_wd1;

  always #5 clk = ~clk;

  assign rfd0_i = mem[ra0_i];
  assign rfd1_i = mem[ra1_i];
  assign rfd2_i = mem[ra2_i];
  assign rfd3_i = mem[ra3_i];

  wb_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid_i(wb0_valid_i), .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
    .wb1_valid_i(wb1_valid_i), .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
    .wb_ready_o(wb_ready_o),
    .wa0_o(wa0_o), .wd0_o(wd0_o), .we0_o(we0_o),
    .wa1_o(wa1_o), .wd1_o(wd1_o), .we1_o(we1_o),
    .ra0_i(ra0_i), .ra1_i(ra1_i), .ra2_i(ra2_i), .ra3_i(ra3_i),
    .rfd0_i(rfd0_i), .rfd1_i(rfd1_i), .rfd2_i(rfd2_i), .rfd3_i(rfd3_i),
    .rd0_o(rd0_o), .rd1_o(rd1_o), .rd2_o(rd2_o), .rd3_o(rd3_o),
    .pending_cnt_o(pending_cnt_o), .idle_o(idle_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected writes go into the queue of the bank they must appear on.
  task automatic push(input logic [4:0] a, input logic [WIDTH-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (a == 5'd0) begin
    end else if (a[0]) begin
      exp_q1.push_back(e);
    end else begin
      exp_q0.push_back(e);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [WIDTH-1:0] d1);
    wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
    wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
    if (v0) push(a0, d0);
    if (v1) push(a1, d1);
  endtask

  task automatic idle_in();
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
  endtask

  task automatic sb_check();
    wr_t e;
    pend_we0 = we0_o; pend_wa0 = wa0_o; pend_wd0 = wd0_o;
    pend_we1 = we1_o; pend_wa1 = wa1_o; pend_wd1 = wd1_o;
    if (we0_o === 1'b1) begin
      if (exp_q0.size() == 0) begin
        check("sb_p0_unexpected_we", 64'(we0_o), 64'(0));
      end else begin
        e = exp_q0.pop_front();
        check("sb_p0_addr", 64'(wa0_o), 64'(e.addr));
        check("sb_p0_data", 64'(wd0_o), 64'(e.data));
      end
    end
    if (we1_o === 1'b1) begin
      if (exp_q1.size() == 0) begin
        check("sb_p1_unexpected_we", 64'(we1_o), 64'(0));
      end else begin
        e = exp_q1.pop_front();
        check("sb_p1_addr", 64'(wa1_o), 64'(e.addr));
        check("sb_p1_data", 64'(wd1_o), 64'(e.data));
      end
    end
  endtask

  task automatic settle();
    #2;
    sb_check();
  endtask

  // Regfile commits the writes observed during the cycle at the clock edge.
  task automatic tick();
    @(posedge clk);
    if (pend_we0 === 1'b1) mem[pend_wa0] = pend_wd0;
    if (pend_we1 === 1'b1) mem[pend_wa1] = pend_wd1;
    pend_we0 = 1'b0;
    pend_we1 = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt, sent, inflight;
    logic saw_stall;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 32'hDEAD_BEEF;
    pend_we0 = 1'b0; pend_we1 = 1'b0;
    idle_in();
    wb0_addr_i = 5'd0; wb0_data_i = '0; wb1_addr_i = 5'd0; wb1_data_i = '0;
    ra0_i = 5'd0; ra1_i = 5'd0; ra2_i = 5'd0; ra3_i = 5'd0;

    // Reset state
    @(negedge clk); #1;
    check("rst_ready", 64'(wb_ready_o), 64'(0));
    check("rst_cnt", 64'(pending_cnt_o), 64'(0));
    check("rst_we0", 64'(we0_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(wb_ready_o), 64'(1));
    check("rel_idle", 64'(idle_o), 64'(1));

    // Different banks, empty buffer: zero-latency dual issue
    drive(1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
    settle();
    check("diff_we0", 64'(we0_o), 64'(1));
    check("diff_wa0", 64'(wa0_o), 64'(4));
    check("diff_we1", 64'(we1_o), 64'(1));
    check("diff_wa1", 64'(wa1_o), 64'(7));
    check("diff_idle", 64'(idle_o), 64'(0));
    tick();
    idle_in();
    check("diff_cnt", 64'(pending_cnt_o), 64'(0));

    // Same-bank conflict: r2 now, r6 next cycle
    ra0_i = 5'd6;
    drive(1'b1, 5'd2, 32'h11, 1'b1, 5'd6, 32'h22);
    settle();
    check("conf_c0_wa0", 64'(wa0_o), 64'(2));
    check("conf_c0_we1", 64'(we1_o), 64'(0));
    check("conf_c0_rd0_noinput_fwd", 64'(rd0_o), 64'(0));
    tick();
    idle_in();
    check("conf_cnt1", 64'(pending_cnt_o), 64'(1));
    settle();
    check("conf_c1_we0", 64'(we0_o), 64'(1));
    check("conf_c1_wa0", 64'(wa0_o), 64'(6));
    check("conf_c1_rd0_fwd", 64'(rd0_o), 64'(32'h22));
    tick();
    check("conf_cnt0", 64'(pending_cnt_o), 64'(0));

    // Same address: older write first, forwarding shows the younger value
    ra1_i = 5'd5;
    drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
    settle();
    check("same_c0_wd1", 64'(wd1_o), 64'(1));
    check("same_c0_we0", 64'(we0_o), 64'(0));
    tick();
    idle_in();
    settle();
    check("same_c1_wd1", 64'(wd1_o), 64'(2));
    check("same_c1_rd1_fwd", 64'(rd1_o), 64'(2));
    tick();

    // Backpressure: all-even pairs, one issue per cycle
    exp_cnt = 0; sent = 0; saw_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sent >= 8 && exp_cnt == 0) break;
      check("bp_cnt", 64'(pending_cnt_o), 64'(exp_cnt));
      check("bp_ready", 64'(wb_ready_o), 64'(exp_cnt <= DEPTH - 2));
      if (wb_ready_o === 1'b0) saw_stall = 1'b1;
      if ((exp_cnt <= DEPTH - 2) && (sent < 8)) begin
        drive(1'b1, 5'(8 + 2 * sent), WIDTH'(32'h100 + sent),
              1'b1, 5'(10 + 2 * sent), WIDTH'(32'h101 + sent));
        sent += 2;
        inflight = exp_cnt + 2;
      end else begin
        idle_in();
        inflight = exp_cnt;
      end
      settle();
      check("bp_we0", 64'(we0_o), 64'(inflight > 0));
      check("bp_we1", 64'(we1_o), 64'(0));
      tick();
      exp_cnt = (inflight > 0) ? inflight - 1 : 0;
    end
    idle_in();
    check("bp_drained_in_budget", 64'(sent == 8 && exp_cnt == 0), 64'(1));
    check("bp_saw_stall", 64'(saw_stall), 64'(1));
    check("bp_q0_empty", 64'(exp_q0.size()), 64'(0));

    // r0 write dropped, read of r0 returns zero
    ra0_i = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd3, 32'h9);
    settle();
    check("r0_we0", 64'(we0_o), 64'(0));
    check("r0_we1", 64'(we1_o), 64'(1));
    check("r0_wa1", 64'(wa1_o), 64'(3));
    check("r0_rd0", 64'(rd0_o), 64'(0));
    tick();
    idle_in();
    check("r0_cnt", 64'(pending_cnt_o), 64'(0));

    // Reset mid-operation with three entries buffered
    drive(1'b1, 5'd24, 32'h240, 1'b1, 5'd26, 32'h260);
    settle(); tick();
    drive(1'b1, 5'd28, 32'h280, 1'b1, 5'd30, 32'h300);
    settle(); tick();
    drive(1'b1, 5'd2, 32'h20, 1'b1, 5'd4, 32'h40);
    settle(); tick();
    idle_in();
    check("mid_cnt3", 64'(pending_cnt_o), 64'(3));
    rst = 1'b1;
    #1;
    check("mid_rst_we0", 64'(we0_o), 64'(0));
    check("mid_rst_we1", 64'(we1_o), 64'(0));
    check("mid_rst_ready", 64'(wb_ready_o), 64'(0));
    check("mid_rst_cnt", 64'(pending_cnt_o), 64'(0));
    exp_q0.delete();
    exp_q1.delete();
    pend_we0 = 1'b0; pend_we1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_cnt", 64'(pending_cnt_o), 64'(0));
    check("post_rst_ready", 64'(wb_ready_o), 64'(1));
    for (int c = 0; c < 4; c++) begin
      settle();
      check("post_rst_no_we0", 64'(we0_o), 64'(0));
      check("post_rst_no_we1", 64'(we1_o), 64'(0));
      tick();
    end

    // Final regfile contents and scoreboard drain
    check("final_r5", 64'(mem[5]), 64'(2));
    check("final_r6", 64'(mem[6]), 64'(32'h22));
    check("final_q0_empty", 64'(exp_q0.size()), 64'(0));
    check("final_q1_empty", 64'(exp_q1.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
